watch_fnd_scan: RTL

- Display back-end of the watch. Consumes the sec/min/hour count values from the three cascaded tick counters and drives a 6-digit multiplexed 7-segment (FND) display.
- Per-field binary-to-BCD conversion, frame-coherent snapshot, digit scanning with an anti-ghosting blank interval, and a blinking colon point.

---
 rtl/watch_fnd_scan.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/watch_fnd_scan.sv
// rtl/watch_fnd_scan.sv - 6-digit multiplexed FND scan driver for the watch; optional HOUR_LZ_BLANK_EN blanks the hour-tens leading zero
module watch_fnd_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run_en,
  input  logic       i_tick,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic [7:0] o_seg,
  output logic [5:0] o_com
);

  localparam int            PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_DRV   = PW'(BLANK_CYC);
  localparam logic [0:0]    ST_BLANK  = 1'b0;
  localparam logic [0:0]    ST_DRIVE  = 1'b1;
  localparam logic [7:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0]    COM_OFF   = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
  // Internal symbol codes beyond the decimal digits
  localparam logic [3:0]    SYM_MINUS = 4'hA;
  localparam logic [3:0]    SYM_BLANK = 4'hB;

  logic [PW-1:0] prescaler;
  logic [PW-1:0] pre_next;
  logic [2:0]    digit;
  logic [0:0]    state;
  logic          slot_wrap;
  logic          frame_wrap;
  logic [5:0]    sh_sec;
  logic [5:0]    sh_min;
  logic [4:0]    sh_hour;
  logic          colon_on;
  logic [3:0]    sec_t, sec_o, min_t, min_o, hour_t, hour_o;
  logic [3:0]    sym;
  logic [6:0]    glyph;
  logic          dp;
  logic [7:0]    seg_hi;
  logic [5:0]    com_hi;

  assign slot_wrap  = (prescaler == PRE_MAX);
  assign frame_wrap = slot_wrap && (digit == 3'd5);
  assign pre_next   = slot_wrap ? '0 : prescaler + PW'(1);

  // Prescaler, digit index and the BLANK/DRIVE slot state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      digit     <= 3'd0;
      state     <= ST_BLANK;
    end else begin
      prescaler <= pre_next;
      if (slot_wrap) digit <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
      case (state)
        ST_BLANK: if (pre_next == PRE_DRV) state <= ST_DRIVE;
        default:  if (slot_wrap) state <= ST_BLANK;
      endcase
    end
  end

  // Latch the whole time once per frame so all six digits agree
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_sec  <= 6'd0;
      sh_min  <= 6'd0;
      sh_hour <= 5'd0;
    end else if (frame_wrap) begin
      sh_sec  <= i_sec;
      sh_min  <= i_min;
      sh_hour <= i_hour;
    end
  end

  // Colon blinks with the seconds tick while running, steady when stopped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          colon_on <= 1'b1;
    else if (!i_run_en)  colon_on <= 1'b1;
    else if (i_tick)     colon_on <= ~colon_on;
  end

  // Binary to BCD per field, with minus for out-of-range values
  always_comb begin
    sec_t  = 4'(sh_sec / 6'd10);
    sec_o  = 4'(sh_sec % 6'd10);
    min_t  = 4'(sh_min / 6'd10);
    min_o  = 4'(sh_min % 6'd10);
    hour_t = 4'(sh_hour / 5'd10);
    hour_o = 4'(sh_hour % 5'd10);
`ifdef HOUR_LZ_BLANK_EN
    if (sh_hour < 5'd10) hour_t = SYM_BLANK;
`endif
    if (sh_sec > 6'd59) begin
      sec_t = SYM_MINUS;
      sec_o = SYM_MINUS;
    end
    if (sh_min > 6'd59) begin
      min_t = SYM_MINUS;
      min_o = SYM_MINUS;
    end
    if (sh_hour > 5'd23) begin
      hour_t = SYM_MINUS;
      hour_o = SYM_MINUS;
    end
  end

  // Select the indexed digit and encode it as active-high segments
  always_comb begin
    case (digit)
      3'd0:    sym = sec_o;
      3'd1:    sym = sec_t;
      3'd2:    sym = min_o;
      3'd3:    sym = min_t;
      3'd4:    sym = hour_o;
      3'd5:    sym = hour_t;
      default: sym = SYM_BLANK;
    endcase
    case (sym)
      4'd0:      glyph = 7'h3F;
      4'd1:      glyph = 7'h06;
      4'd2:      glyph = 7'h5B;
      4'd3:      glyph = 7'h4F;
      4'd4:      glyph = 7'h66;
      4'd5:      glyph = 7'h6D;
      4'd6:      glyph = 7'h7D;
      4'd7:      glyph = 7'h07;
      4'd8:      glyph = 7'h7F;
      4'd9:      glyph = 7'h6F;
      SYM_MINUS: glyph = 7'h40;
      default:   glyph = 7'h00;
    endcase
    dp     = colon_on && ((digit == 3'd2) || (digit == 3'd4));
    seg_hi = {dp, glyph};
    com_hi = 6'b000001 << digit;
  end

  // Registered outputs: everything off during BLANK, indexed digit during DRIVE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_seg <= SEG_OFF;
      o_com <= COM_OFF;
    end else if (state == ST_DRIVE) begin
      o_seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      o_com <= SEG_ACTIVE_LOW ? ~com_hi : com_hi;
    end else begin
      o_seg <= SEG_OFF;
      o_com <= COM_OFF;
    end
  end

endmodule
